// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with age-based LRU replacement.
// Fetch lookups are combinational and independent per port. The branch
// resolution path writes or invalidates one entry per cycle. A flush clears
// every valid bit in one cycle.
//
// Update strobe: an update record is consumed in any cycle where
// upd_valid_i is high at the rising clock edge. There is no back-pressure.
// A flush or reset in the same cycle drops the record. The effect is
// visible to lookups from the following cycle.
module btb_assoc #(
    parameter int PC_BITS  = 32,
    parameter int SETS     = 16,
    parameter int WAYS     = 2,
    parameter int RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*PC_BITS-1:0]  rd_pc_i,
    output logic [RD_PORTS-1:0]          rd_hit_o,
    output logic [RD_PORTS*PC_BITS-1:0]  rd_target_o,
    input  logic                         upd_valid_i,
    input  logic                         upd_taken_i,
    input  logic [PC_BITS-1:0]           upd_pc_i,
    input  logic [PC_BITS-1:0]           upd_target_i,
    input  logic                         flush_i,
    output logic                         evict_o
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Entry storage. Only the valid bits are reset. Stale tag/target
    // contents are harmless because a miss forces the target to zero.
    logic [WAYS-1:0]    valid_q [SETS];
    logic [PC_BITS-1:0] tag_q   [SETS][WAYS];
    logic [PC_BITS-1:0] tgt_q   [SETS][WAYS];
    logic               evict_q;

    // Update-side decode for the set addressed by upd_pc_i.
    logic [IDX_BITS-1:0] upd_idx;
    logic [WAYS-1:0]     upd_way_hit;
    logic                upd_hit;
    logic [WAY_BITS-1:0] hit_way;
    logic                any_inv;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] lru_way;
    logic [WAY_BITS-1:0] wr_way;
    logic                do_write;
    logic                do_inval;

    assign upd_idx = upd_pc_i[IDX_BITS:1];

    // Per-port lookup, with the target gated to zero on a miss.
    for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_rd
        logic [PC_BITS-1:0]  pc;
        logic [IDX_BITS-1:0] idx;
        logic [WAYS-1:0]     way_hit;
        logic [PC_BITS-1:0]  tgt;

        assign pc  = rd_pc_i[gp*PC_BITS +: PC_BITS];
        assign idx = pc[IDX_BITS:1];

        // Compare the full PC against each way of the indexed set and OR the hit targets.
        always_comb begin
            way_hit = '0;
            tgt     = '0;
            for (int w = 0; w < WAYS; w++) begin
                way_hit[w] = valid_q[idx][w] && (tag_q[idx][w] == pc);
                if (way_hit[w]) begin
                    tgt = tgt | tgt_q[idx][w];
                end
            end
        end

        assign rd_hit_o[gp]                          = |way_hit;
        assign rd_target_o[gp*PC_BITS +: PC_BITS]    = tgt;

`ifndef SYNTHESIS
        // At most one way may ever hold a given PC.
        always_ff @(posedge clk) begin
            if (!rst) begin
                assert ($onehot0(way_hit));
            end
        end
`endif
    end

    // Hit detection and way selection for the update set.
    // The downward scan of the invalid ways means the lowest index wins.
    always_comb begin
        upd_way_hit = '0;
        hit_way     = '0;
        any_inv     = 1'b0;
        inv_way     = '0;
        for (int w = 0; w < WAYS; w++) begin
            upd_way_hit[w] = valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_pc_i);
            if (upd_way_hit[w]) begin
                hit_way = WAY_BITS'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
    end

    assign upd_hit  = |upd_way_hit;
    assign wr_way   = upd_hit ? hit_way : (any_inv ? inv_way : lru_way);
    assign do_write = upd_valid_i && upd_taken_i && !flush_i && !rst;
    assign do_inval = upd_valid_i && !upd_taken_i && upd_hit && !flush_i && !rst;

`ifndef SYNTHESIS
    // Check that the update set also holds at most one copy of the PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(upd_way_hit));
        end
    end
`endif

    if (WAYS > 1) begin : g_age
        logic [WAY_BITS-1:0] age_q [SETS][WAYS];

        // The LRU way is the one whose age has reached WAYS-1.
        always_comb begin
            lru_way = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[upd_idx][w] == WAY_BITS'(WAYS - 1)) begin
                    lru_way = WAY_BITS'(w);
                end
            end
        end

        // Age update: the touched way becomes 0, and younger ways age by one.
        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[s][w] <= WAY_BITS'(w);
                    end
                end
            end else if (do_write) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_BITS'(w) == wr_way) begin
                        age_q[upd_idx][w] <= '0;
                    end else if (age_q[upd_idx][w] < age_q[upd_idx][wr_way]) begin
                        age_q[upd_idx][w] <= age_q[upd_idx][w] + 1'b1;
                    end
                end
            end
        end
    end else begin : g_no_age
        assign lru_way = '0;
    end

    // Valid bits. Reset and flush clear them. A taken update sets one bit
    // and a not-taken hit clears one bit.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (do_write) begin
            valid_q[upd_idx][wr_way] <= 1'b1;
        end else if (do_inval) begin
            valid_q[upd_idx][hit_way] <= 1'b0;
        end
    end

    // Tag and target payload, written only on an accepted taken update.
    always_ff @(posedge clk) begin
        if (do_write) begin
            tag_q[upd_idx][wr_way] <= upd_pc_i;
            tgt_q[upd_idx][wr_way] <= upd_target_i;
        end
    end

    // Eviction pulse: a taken miss into a set with no free way.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            evict_q <= 1'b0;
        end else begin
            evict_q <= do_write && !upd_hit && !any_inv;
        end
    end

    assign evict_o = evict_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with default parameters (index = pc[4:1]).
module tb_btb_assoc;

    localparam int PC_BITS  = 32;
    localparam int RD_PORTS = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [RD_PORTS*PC_BITS-1:0] rd_pc_i;
    logic [RD_PORTS-1:0]         rd_hit_o;
    logic [RD_PORTS*PC_BITS-1:0] rd_target_o;
    logic                        upd_valid_i;
    logic                        upd_taken_i;
    logic [PC_BITS-1:0]          upd_pc_i;
    logic [PC_BITS-1:0]          upd_target_i;
    logic                        flush_i;
    logic                        evict_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected evict_o value for each update, checked in the following cycle.
    logic [0:0] exp_q[$];

    btb_assoc #(
        .PC_BITS (PC_BITS),
        .SETS    (16),
        .WAYS    (2),
        .RD_PORTS(RD_PORTS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_pc_i     (rd_pc_i),
        .rd_hit_o    (rd_hit_o),
        .rd_target_o (rd_target_o),
        .upd_valid_i (upd_valid_i),
        .upd_taken_i (upd_taken_i),
        .upd_pc_i    (upd_pc_i),
        .upd_target_i(upd_target_i),
        .flush_i     (flush_i),
        .evict_o     (evict_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive both lookup ports and check the hit vector and both targets.
    task automatic look(input string tag, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] hit, input logic [31:0] t0, input logic [31:0] t1);
        rd_pc_i = {pc1, pc0};
        #1;
        chk({tag, "_hit"}, {30'd0, rd_hit_o}, {30'd0, hit});
        chk({tag, "_t0"}, rd_target_o[31:0], t0);
        chk({tag, "_t1"}, rd_target_o[63:32], t1);
    endtask

    // Present one update for one cycle, then check evict_o in the next cycle.
    task automatic upd(input logic taken, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic exp_evict);
        upd_valid_i  = 1'b1;
        upd_taken_i  = taken;
        upd_pc_i     = pc;
        upd_target_i = tgt;
        exp_q.push_back(exp_evict);
        @(negedge clk);
        upd_valid_i = 1'b0;
        upd_taken_i = 1'b0;
        #1;
        chk("evict", {31'd0, evict_o}, {31'd0, exp_q.pop_front()});
    endtask

    // Run one cycle with no update and check that no eviction pulse is pending.
    task automatic idle();
        @(negedge clk);
        #1;
        chk("evict_idle", {31'd0, evict_o}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        rd_pc_i      = '0;
        upd_valid_i  = 1'b0;
        upd_taken_i  = 1'b0;
        upd_pc_i     = '0;
        upd_target_i = '0;
        flush_i      = 1'b0;

        // 1. Reset for two cycles.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        look("rst", 32'h100, 32'h0, 2'b00, 32'h0, 32'h0);
        chk("rst_evict", {31'd0, evict_o}, 32'd0);

        // 2. Insert and visibility, with no same-cycle bypass.
        upd_valid_i  = 1'b1;
        upd_taken_i  = 1'b1;
        upd_pc_i     = 32'h100;
        upd_target_i = 32'h200;
        look("same_cyc", 32'h100, 32'h122, 2'b00, 32'h0, 32'h0);
        exp_q.push_back(1'b0);
        @(negedge clk);
        upd_valid_i = 1'b0;
        upd_taken_i = 1'b0;
        #1;
        chk("evict", {31'd0, evict_o}, {31'd0, exp_q.pop_front()});
        look("next_cyc", 32'h100, 32'h122, 2'b01, 32'h200, 32'h0);
        upd(1'b1, 32'h122, 32'h322, 1'b0);
        look("two_sets", 32'h100, 32'h122, 2'b11, 32'h200, 32'h322);

        // 3a. LRU replacement: the third index-0 insert evicts 0x100.
        upd(1'b1, 32'h120, 32'h220, 1'b0);
        upd(1'b1, 32'h140, 32'h240, 1'b1);
        look("lru_a1", 32'h100, 32'h120, 2'b10, 32'h0, 32'h220);
        look("lru_a2", 32'h140, 32'h122, 2'b11, 32'h240, 32'h322);
        idle();

        // 3b. Re-updating 0x100 makes 0x120 the victim instead.
        upd_valid_i = 1'b0;
        flush_i     = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        look("flush_only", 32'h140, 32'h122, 2'b00, 32'h0, 32'h0);
        upd(1'b1, 32'h100, 32'h200, 1'b0);
        upd(1'b1, 32'h120, 32'h220, 1'b0);
        upd(1'b1, 32'h100, 32'h2a0, 1'b0);
        upd(1'b1, 32'h140, 32'h240, 1'b1);
        look("lru_b1", 32'h100, 32'h120, 2'b01, 32'h2a0, 32'h0);
        look("lru_b2", 32'h140, 32'h0, 2'b01, 32'h240, 32'h0);

        // 4. Not-taken invalidation frees a way for a later insert.
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        upd(1'b1, 32'h100, 32'h200, 1'b0);
        upd(1'b1, 32'h120, 32'h220, 1'b0);
        upd(1'b0, 32'h120, 32'h0, 1'b0);
        look("inval", 32'h100, 32'h120, 2'b01, 32'h200, 32'h0);
        upd(1'b0, 32'h160, 32'h0, 1'b0);
        look("nt_miss", 32'h100, 32'h160, 2'b01, 32'h200, 32'h0);
        upd(1'b1, 32'h140, 32'h240, 1'b0);
        look("refill", 32'h100, 32'h140, 2'b11, 32'h200, 32'h240);

        // 5. Flush together with a would-be evicting update of 0x300.
        flush_i = 1'b1;
        upd(1'b1, 32'h300, 32'h400, 1'b0);
        flush_i = 1'b0;
        look("flush_a", 32'h300, 32'h100, 2'b00, 32'h0, 32'h0);
        look("flush_b", 32'h140, 32'h0, 2'b00, 32'h0, 32'h0);

        // 6. Reset in the same cycle as an evicting update.
        upd(1'b1, 32'h100, 32'h200, 1'b0);
        upd(1'b1, 32'h120, 32'h220, 1'b0);
        rst = 1'b1;
        upd(1'b1, 32'h140, 32'h240, 1'b0);
        rst = 1'b0;
        look("mid_rst_a", 32'h100, 32'h120, 2'b00, 32'h0, 32'h0);
        look("mid_rst_b", 32'h140, 32'h0, 2'b00, 32'h0, 32'h0);
        // Fresh inserts: 0x100 lands in way 0, so it is the first victim.
        upd(1'b1, 32'h100, 32'h500, 1'b0);
        upd(1'b1, 32'h120, 32'h520, 1'b0);
        upd(1'b1, 32'h140, 32'h540, 1'b1);
        look("post_rst_a", 32'h100, 32'h120, 2'b10, 32'h0, 32'h520);
        look("post_rst_b", 32'h140, 32'h0, 2'b01, 32'h540, 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the IF stage. It generalises the single-array BTB to configurable sets, ways and fetch read ports, with age-based LRU replacement. It also supports explicit invalidation on not-taken resolution, a global flush, and an eviction indicator for verification. Fetch looks up target PCs combinationally each cycle; the branch resolution path writes `predictor_update`-style records into it.

## Interface
- `PC_BITS`, 32: PC width.
- `SETS`, 16: number of sets; power of 2, ≥2.
- `WAYS`, 2: associativity; one of 1, 2, 4, 8.
- `RD_PORTS`, 2: number of parallel fetch lookups.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rd_pc_i`  in  RD_PORTS×PC_BITS: lookup PCs.
- `rd_hit_o`  out  RD_PORTS: lookup hit.
- `rd_target_o`  out  RD_PORTS×PC_BITS: predicted target; 0 on miss.
- `upd_valid_i`  in  1: update strobe (`valid_jump`).
- `upd_taken_i`  in  1: resolved taken (`jump_taken`).
- `upd_pc_i`  in  PC_BITS: branch PC (`orig_pc`).
- `upd_target_i`  in  PC_BITS: resolved target (`jump_address`).
- `flush_i`  in  1: invalidate entire BTB.
- `evict_o`  out  1: registered pulse; a valid entry was replaced.

## Operation
- **Index:** `pc[log2(SETS):1]`, with bit 0 ignored because of 2-byte compressed alignment. Each entry holds `{valid, orig_pc[PC_BITS-1:0], target}`. A hit requires the full orig_pc to match plus `valid`.
- **Read:** purely combinational per port, against current array contents.
  - Ports are independent.
  - Reads never touch LRU state.
  - At most one way matches per set (this is an invariant; flag an assertion if violated).
- **Update with `upd_valid_i && upd_taken_i`:**
  - If it hits in the set, overwrite the target and make that way MRU. `evict_o`=0.
  - Otherwise write to the lowest-index invalid way. `evict_o`=0.
  - Otherwise write to the LRU way. `evict_o`=1.
  - The written way becomes MRU.
- **Update with `upd_valid_i && !upd_taken_i`:** if it hits, clear that way's valid bit. Ages are unchanged. A miss is a no-op.
- **LRU:** each set keeps a distinct age per way, each age in `0..WAYS-1`.
  - Touching way k: every way with age < age_k increments, and age_k becomes 0.
  - The LRU way is the one with age WAYS-1.
  - WAYS=1: no age state; the victim is always way 0.
- **Flush:** clears all valid bits and restores every set's ages to their reset values, in one cycle.
- **Reset:** all valid bits = 0; age[w] = w in every set; `evict_o` = 0.
  - Stored PC and target fields may stay uninitialised.
  - Outputs are still clean, because a miss forces target to 0.

## Timing
- Lookup latency: 0 cycles (combinational).
- An update presented in cycle N is visible to lookups from cycle N+1. There is no write-to-read bypass: a same-cycle lookup of `upd_pc_i` sees the old contents.
- `evict_o` asserts in cycle N+1 for one cycle per evicting update.
- **Priority:** `rst` > `flush_i` > update.
  - A flush in the same cycle as an update drops the update, and `evict_o` stays 0.
  - Reset asserted mid-stream discards any in-flight effects. Lookups miss from the cycle after reset.
- Back-to-back updates to the same set in consecutive cycles must both take effect. The second update sees the first update's ages and valid bits.
- Ages are wrap-free by construction; no counter exceeds WAYS-1.

## Test plan
Default parameters apply unless stated; index = `pc[4:1]`.
1. **Reset:** hold `rst` for 2 cycles, then look up 0x100 and 0x0 → `rd_hit_o`=00, targets 0, `evict_o`=0.
2. **Insert and visibility:** taken update 0x100→0x200 in cycle N; look up 0x100 in cycle N → miss; in cycle N+1 → hit, target 0x200. Port 1 looks up 0x122 → miss, independently.
3. **LRU replacement:** insert 0x100, then 0x120, then 0x140 (all index 0) → 0x100 is evicted and `evict_o`=1 one cycle later; 0x120 and 0x140 hit. Repeat with a re-update of 0x100 before inserting 0x140 → 0x120 is evicted instead.
4. **Not-taken invalidation:** after 0x100 and 0x120 are resident, a not-taken update of 0x120 → 0x120 misses next cycle. A subsequent insert of 0x140 fills the freed way with `evict_o`=0, and 0x100 still hits.
5. **Flush collision:** with entries resident, assert `flush_i` together with a taken update of 0x300 → every lookup misses next cycle, including 0x300, and `evict_o`=0.
6. **Reset mid-operation:** assert `rst` in the same cycle as an evicting update → `evict_o` stays 0 and every lookup misses afterwards. A fresh insert then uses way 0.
